// File: rtl/blockhammer_pkg.sv
// Shared BlockHammer widths and the row-history entry type.
// Row/core widths must agree with bloom_filters, which imports this package too.
package blockhammer_pkg;

    localparam int ROW_W     = 16;
    localparam int CORE_W    = 3;
    // Wide enough to hold a timer preset of T_DELAY=1024
    localparam int T_DELAY_W = 11;
    localparam int STAT_W    = 32;

    typedef struct packed {
        logic                 valid;
        logic [ROW_W-1:0]     row;
        logic [T_DELAY_W-1:0] timer;
    } rhb_entry_t;

endpackage

// File: rtl/rhb_match_cam.sv
// Combinational CAM: hit when i_query_row equals the row of any valid entry.
module rhb_match_cam
    import blockhammer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]            i_valid,
    input  logic [DEPTH-1:0][ROW_W-1:0] i_rows,
    input  logic [ROW_W-1:0]            i_query_row,
    output logic                        o_hit
);

    logic [DEPTH-1:0] w_hit_vec;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign w_hit_vec[gi] = i_valid[gi] & (i_rows[gi] == i_query_row);
    end

    assign o_hit = |w_hit_vec;

endmodule

// File: rtl/row_history_buffer.sv
// BlockHammer row history buffer: FIFO of blacklisted ACTs with countdown timers.
// Optional saturating stat counters are built when BLOCKHAMMER_RHB_STATS_EN is defined.
module row_history_buffer
    import blockhammer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int T_DELAY = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         act_valid,
    input  logic [ROW_W-1:0]             act_row,
    input  logic [CORE_W-1:0]            act_core,
    input  logic                         act_blacklisted,
    input  logic                         query_valid,
    input  logic [ROW_W-1:0]             query_row,
    input  logic                         query_blacklisted,
    output logic                         query_safe,
    output logic [$clog2(DEPTH+1)-1:0]   hb_count,
    output logic                         hb_full,
    output logic                         hb_overflow,
    output logic [STAT_W-1:0]            stat_blocked,
    output logic [STAT_W-1:0]            stat_inserted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    rhb_entry_t [DEPTH-1:0] r_entries;
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;
    logic                   r_overflow;

    logic                        w_req;
    logic                        w_pop;
    logic                        w_not_full;
    logic                        w_ins;
    logic                        w_drop;
    logic                        w_bypass;
    logic                        w_cam_hit;
    logic                        w_match;
    logic                        w_full;
    logic                        w_safe;
    logic [DEPTH-1:0]            w_valid_vec;
    logic [DEPTH-1:0][ROW_W-1:0] w_rows;

    assign w_req      = act_valid & act_blacklisted;
    // Uniform delay keeps entries age-ordered, so only the head can expire
    assign w_pop      = r_entries[r_head].valid & (r_entries[r_head].timer == T_DELAY_W'(1));
    assign w_not_full = r_count < CNT_W'(DEPTH);
    assign w_ins      = w_req & (w_not_full | w_pop);
    assign w_drop     = w_req & ~w_not_full & ~w_pop;

    always_comb begin
        w_valid_vec = '0;
        w_rows      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_vec[i] = r_entries[i].valid;
            w_rows[i]      = r_entries[i].row;
        end
    end

    rhb_match_cam #(.DEPTH(DEPTH)) u_cam (
        .i_valid     (w_valid_vec),
        .i_rows      (w_rows),
        .i_query_row (query_row),
        .o_hit       (w_cam_hit)
    );

    // Same-cycle ACT to the queried row must already count as recent
    assign w_bypass = w_req & (act_row == query_row);
    assign w_match  = w_cam_hit | w_bypass;
    assign w_full   = (r_count == CNT_W'(DEPTH)) & ~w_pop;
    assign w_safe   = ~rst_n | ~(query_blacklisted & (w_match | w_full));

    // Insert is applied after pop so a full-buffer swap reuses the head slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entries <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_entries[i].valid)
                    r_entries[i].timer <= r_entries[i].timer - T_DELAY_W'(1);
                if (w_pop && (r_head == PTR_W'(i)))
                    r_entries[i].valid <= 1'b0;
                if (w_ins && (r_tail == PTR_W'(i)))
                    r_entries[i] <= '{valid: 1'b1, row: act_row, timer: T_DELAY_W'(T_DELAY)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            if (w_ins)
                r_tail <= r_tail + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_ins) - CNT_W'(w_pop);
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    assign query_safe  = w_safe;
    assign hb_count    = r_count;
    assign hb_full     = w_full;
    assign hb_overflow = r_overflow;

`ifdef BLOCKHAMMER_RHB_STATS_EN
    logic [STAT_W-1:0] r_stat_blocked;
    logic [STAT_W-1:0] r_stat_inserted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_blocked  <= '0;
            r_stat_inserted <= '0;
        end else begin
            if (query_valid && !w_safe && (r_stat_blocked != '1))
                r_stat_blocked <= r_stat_blocked + STAT_W'(1);
            if (w_ins && (r_stat_inserted != '1))
                r_stat_inserted <= r_stat_inserted + STAT_W'(1);
        end
    end

    assign stat_blocked  = r_stat_blocked;
    assign stat_inserted = r_stat_inserted;

    // act_core is carried for future per-core accounting only
    logic w_unused;
    assign w_unused = ^act_core;
`else
    assign stat_blocked  = '0;
    assign stat_inserted = '0;

    logic w_unused;
    assign w_unused = ^{act_core, query_valid};
`endif

endmodule

// File: tb/tb_row_history_buffer.sv
// Scoreboard bench for row_history_buffer (DEPTH=4, T_DELAY=8), directed vectors.
module tb_row_history_buffer;

    logic        clk;
    logic        rst_n;
    logic        act_valid;
    logic [15:0] act_row;
    logic [2:0]  act_core;
    logic        act_blacklisted;
    logic        query_valid;
    logic [15:0] query_row;
    logic        query_blacklisted;
    logic        query_safe;
    logic [2:0]  hb_count;
    logic        hb_full;
    logic        hb_overflow;
    logic [31:0] stat_blocked;
    logic [31:0] stat_inserted;

    typedef struct {
        string       name;
        bit          safe;
        int          cnt;
        bit          full;
        bit          ovf;
        logic [31:0] blk;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_blk    = 0;
    int   n_ins    = 0;

    row_history_buffer #(.DEPTH(4), .T_DELAY(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .act_valid         (act_valid),
        .act_row           (act_row),
        .act_core          (act_core),
        .act_blacklisted   (act_blacklisted),
        .query_valid       (query_valid),
        .query_row         (query_row),
        .query_blacklisted (query_blacklisted),
        .query_safe        (query_safe),
        .hb_count          (hb_count),
        .hb_full           (hb_full),
        .hb_overflow       (hb_overflow),
        .stat_blocked      (stat_blocked),
        .stat_inserted     (stat_inserted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".safe"},  32'(query_safe),  32'(e.safe));
            chk({e.name, ".count"}, 32'(hb_count),    32'(e.cnt));
            chk({e.name, ".full"},  32'(hb_full),     32'(e.full));
            chk({e.name, ".ovf"},   32'(hb_overflow), 32'(e.ovf));
            chk({e.name, ".sblk"},  stat_blocked,     e.blk);
            chk({e.name, ".sins"},  stat_inserted,    e.ins);
        end
    end

    task automatic push_exp(input string nm, input bit es, input int ec, input bit ef, input bit eo);
        exp_t e;
        e.name = nm; e.safe = es; e.cnt = ec; e.full = ef; e.ovf = eo;
`ifdef BLOCKHAMMER_RHB_STATS_EN
        e.blk = 32'(n_blk); e.ins = 32'(n_ins);
`else
        e.blk = '0; e.ins = '0;
`endif
        sb.push_back(e);
    endtask

    // One clock cycle: drive inputs just after the edge, optionally queue an expectation
    task automatic cyc(input string nm,
                       input bit av, input logic [15:0] ar, input bit ab,
                       input bit qv, input logic [15:0] qr, input bit qb,
                       input bit ck, input bit es, input int ec, input bit ef, input bit eo,
                       input bit acc);
        @(posedge clk); #1;
        act_valid = av; act_row = ar; act_blacklisted = ab; act_core = ar[2:0];
        query_valid = qv; query_row = qr; query_blacklisted = qb;
        if (ck) begin
            push_exp(nm, es, ec, ef, eo);
            if (qv && !es) n_blk++;
        end
        if (acc) n_ins++;
    endtask

    task automatic idle();
        cyc("idle", 0, 16'h0, 0, 0, 16'h0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    // Reset asserted between edges, with a blacklisted live row queried and a bypass candidate
    task automatic reset_mid(input string nm, input logic [15:0] qr);
        @(posedge clk); #1;
        act_valid = 1; act_row = qr; act_blacklisted = 1;
        query_valid = 1; query_row = qr; query_blacklisted = 1;
        rst_n = 1'b0;
        n_blk = 0; n_ins = 0;
        push_exp(nm, 1, 0, 0, 0);
        @(negedge clk); #1;
        act_valid = 0; query_valid = 0; query_blacklisted = 0; act_blacklisted = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        act_valid = 1; act_row = 16'h1111; act_blacklisted = 1; act_core = '0;
        query_valid = 1; query_row = 16'h1111; query_blacklisted = 1;
        push_exp("rst", 1, 0, 0, 0);
        @(negedge clk); #1;
        act_valid = 0; query_valid = 0; act_blacklisted = 0; query_blacklisted = 0;
        rst_n = 1'b1;

        // T1: lifetime c..c+8 blocked, gone at c+9
        cyc("t1_byp", 1, 16'h1234, 1, 1, 16'h1234, 1, 1, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 8; k++)
            cyc("t1_live", 0, 16'h0, 0, 1, 16'h1234, 1, 1, 0, 1, 0, 0, 0);
        cyc("t1_exp", 0, 16'h0, 0, 1, 16'h1234, 1, 1, 1, 0, 0, 0, 0);

        // T2: non-blacklisted ACT is ignored
        cyc("t2_nobl",  1, 16'h0042, 0, 1, 16'h0042, 1, 1, 1, 0, 0, 0, 0);
        cyc("t2_after", 0, 16'h0000, 0, 1, 16'h0042, 1, 1, 1, 0, 0, 0, 0);

        // T3: matching row with query_blacklisted=0 is safe
        cyc("t3_ins",  1, 16'h00AA, 1, 1, 16'h00AA, 0, 1, 1, 0, 0, 0, 1);
        cyc("t3_nbl",  0, 16'h0000, 0, 1, 16'h00AA, 0, 1, 1, 1, 0, 0, 0);
        cyc("t3_bl",   0, 16'h0000, 0, 1, 16'h00AA, 1, 1, 0, 1, 0, 0, 0);
        repeat (5) idle();
        cyc("t3_last", 0, 16'h0000, 0, 1, 16'h00AA, 1, 1, 0, 1, 0, 0, 0);
        cyc("t3_gone", 0, 16'h0000, 0, 1, 16'h00AA, 1, 1, 1, 0, 0, 0, 0);

        // T4: fill, full blocks unrelated blacklisted rows, drop sets sticky overflow
        cyc("t4_f0",   1, 16'h0101, 1, 1, 16'h7777, 1, 1, 1, 0, 0, 0, 1);
        cyc("t4_f1",   1, 16'h0202, 1, 1, 16'h7777, 1, 1, 1, 1, 0, 0, 1);
        cyc("t4_f2",   1, 16'h0303, 1, 1, 16'h7777, 1, 1, 1, 2, 0, 0, 1);
        cyc("t4_f3",   1, 16'h0404, 1, 1, 16'h7777, 1, 1, 1, 3, 0, 0, 1);
        cyc("t4_full", 1, 16'h0505, 1, 1, 16'h7777, 1, 1, 0, 4, 1, 0, 0);
        cyc("t4_ovf",  0, 16'h0000, 0, 1, 16'h7777, 0, 1, 1, 4, 1, 1, 0);
        repeat (2) idle();
        cyc("t4_pop",  0, 16'h0000, 0, 1, 16'h7777, 1, 1, 1, 4, 0, 1, 0);
        cyc("t4_cnt3", 0, 16'h0000, 0, 1, 16'h7777, 1, 1, 1, 3, 0, 1, 0);
        repeat (2) idle();
        cyc("t4_empty", 0, 16'h0000, 0, 1, 16'h0505, 1, 1, 1, 0, 0, 1, 0);

        // T6: three live entries, asynchronous reset between edges
        cyc("t6_i0",   1, 16'h0C01, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 1);
        cyc("t6_i1",   1, 16'h0C02, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 1);
        cyc("t6_live", 1, 16'h0C03, 1, 1, 16'h0C01, 1, 1, 0, 2, 0, 1, 1);
        reset_mid("t6_rst", 16'h0C01);

        // T5: insert on the pop cycle of a full buffer is accepted
        cyc("t5_i0",   1, 16'h0B01, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 1);
        cyc("t5_i1",   1, 16'h0B02, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 1);
        cyc("t5_i2",   1, 16'h0B03, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 1);
        cyc("t5_f3",   1, 16'h0B04, 1, 1, 16'h0B01, 1, 1, 0, 3, 0, 0, 1);
        cyc("t5_full", 0, 16'h0000, 0, 1, 16'h0B01, 1, 1, 0, 4, 1, 0, 0);
        repeat (3) idle();
        cyc("t5_swap", 1, 16'h0B05, 1, 1, 16'h0B05, 1, 1, 0, 4, 0, 0, 1);
        cyc("t5_keep", 0, 16'h0000, 0, 1, 16'h0B05, 1, 1, 0, 4, 0, 0, 0);
        repeat (2) idle();
        cyc("t5_cnt1", 0, 16'h0000, 0, 1, 16'h0B05, 1, 1, 0, 1, 0, 0, 0);
        repeat (3) idle();
        cyc("t5_last", 0, 16'h0000, 0, 1, 16'h0B05, 1, 1, 0, 1, 0, 0, 0);
        cyc("t5_gone", 0, 16'h0000, 0, 1, 16'h0B05, 1, 1, 1, 0, 0, 0, 0);

        repeat (2) idle();
        @(negedge clk); #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
